// File: rtl/shift_pkg.sv
// Shared types and encodings for the sequential shifter.
// Build option: SHIFT_SEQ_PIPE_EN (overlap response and next accept).
package shift_pkg;

  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_SRA = 4'b0111;

  localparam int STEP_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  function automatic logic op_legal(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/shift_step.sv
// One k-bit shift of the working value; SRA fills from the
// sign of the original operand, not the current value.
module shift_step
  import shift_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] value,
  input  logic [4:0]  k,
  input  logic        sign,
  output logic [31:0] result
);

  logic [31:0] fill;

  always_comb begin
    fill   = sign ? ~(32'hFFFF_FFFF >> k) : 32'h0;
    result = value;
    unique case (1'b1)
      (op == OP_SLL): result = value << k;
      (op == OP_SRL): result = value >> k;
      (op == OP_SRA): result = (value >> k) | fill;
      default:        result = value;
    endcase
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shifter: IDLE -> SHIFT (STEP bits/cycle) -> DONE.
// Build option: SHIFT_SEQ_PIPE_EN lets DONE accept the next request.
module shift_seq_ctrl
  import shift_pkg::*;
#(
  parameter int STEP = STEP_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        busy
);

  localparam logic [4:0] STEP_K = 5'(STEP);

  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] work_q, work_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        sign_q, sign_d;
  logic [4:0]  k;
  logic [31:0] step_out;
  logic        unused_b;

  assign unused_b = ^req_b[31:5];
  assign k = (cnt_q > STEP_K) ? STEP_K : cnt_q;

  shift_step u_step (
    .op     (op_q),
    .value  (work_q),
    .k      (k),
    .sign   (sign_q),
    .result (step_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= 4'h0;
      work_q  <= 32'h0;
      cnt_q   <= 5'h0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    sign_d    = sign_q;
    req_ready = 1'b0;

    unique case (state_q)
      ST_IDLE: req_ready = 1'b1;
      ST_SHIFT: begin
        work_d = step_out;
        cnt_d  = cnt_q - k;
        if (cnt_d == 5'h0) state_d = ST_DONE;
      end
      ST_DONE: begin
`ifdef SHIFT_SEQ_PIPE_EN
        req_ready = rsp_ready;
`endif
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush) req_ready = 1'b0;

    // Accept overrides the DONE->IDLE move in the pipelined build.
    if (req_valid && req_ready) begin
      op_d   = req_op;
      cnt_d  = req_b[4:0];
      sign_d = req_a[31];
      work_d = req_a;
      if (!op_legal(req_op)) begin
        work_d  = 32'h0;
        state_d = ST_DONE;
      end else if (req_b[4:0] == 5'h0) begin
        state_d = ST_DONE;
      end else begin
        state_d = ST_SHIFT;
      end
    end

    if (flush) begin
      state_d = ST_IDLE;
      work_d  = 32'h0;
      cnt_d   = 5'h0;
    end
  end

  assign rsp_valid  = (state_q == ST_DONE);
  assign rsp_result = rsp_valid ? work_q : 32'h0;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 SHALL have parameter: STEP, 4, shift distance per cycle; legal values 1, 2, 4, 8, 16.
REQ-002 SHALL have port: clk  input  1  single clock, rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: flush  input  1  synchronous abort of the in-flight operation.
REQ-005 SHALL have port: req_valid  input  1  request present.
REQ-006 SHALL have port: req_ready  output  1  request accepted when high with req_valid.
REQ-007 SHALL have port: req_op  input  4  0101 SLL, 0110 SRL, 0111 SRA; all other codes are illegal.
REQ-008 SHALL have port: req_a  input  32  operand to be shifted.
REQ-009 SHALL have port: req_b  input  32  shift amount source; only bits [4:0] are used.
REQ-010 SHALL have port: rsp_valid  output  1  result present.
REQ-011 SHALL have port: rsp_ready  input  1  result consumed when high with rsp_valid.
REQ-012 SHALL have port: rsp_result  output  32  shifted result.
REQ-013 SHALL have port: busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-015 IDLE SHALL drive req_ready=1; on accept, SHALL latch op, operand and cnt=req_b[4:0].
REQ-016 On accept, an illegal op SHALL load result 0 and go to DONE.
REQ-017 On accept, a legal op with cnt=0 SHALL load result=req_a and go to DONE.
REQ-018 On accept, any other request SHALL go to SHIFT.
REQ-019 SHIFT SHALL, each cycle, shift the working value by k=min(STEP,cnt), decrement cnt by k, and go to DONE when cnt reaches 0.
REQ-020 Shifts SHALL follow the op: SLL zero-fills the LSBs; SRL zero-fills the MSBs; SRA replicates bit 31 of the original operand.
REQ-021 Latency SHALL be fixed: accept at edge t drives rsp_valid=1 from cycle t+1+ceil(cnt/STEP).
REQ-022 DONE SHALL drive rsp_valid=1, holding rsp_result stable until rsp_ready=1, then go to IDLE.
REQ-023 rsp_result SHALL be 0 whenever rsp_valid=0.
REQ-024 flush=1 SHALL force IDLE on the next edge and discard any result with no response, regardless of state.
REQ-025 If flush and req_valid are high in the same cycle, flush SHALL win and the request SHALL NOT be accepted (req_ready=0 while flush=1).
REQ-026 req_ready SHALL be 0 in SHIFT and DONE, except as allowed by REQ-031.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, cnt=0, working value 0, rsp_valid=0, rsp_result=0 and busy=0.
REQ-028 In IDLE after reset, req_ready SHALL be 1.
REQ-029 Reset asserted mid-SHIFT or mid-DONE SHALL discard the operation; no response is produced after release.

Configuration
REQ-030 SHALL use the macro SHIFT_SEQ_PIPE_EN.
REQ-031 With SHIFT_SEQ_PIPE_EN defined, DONE SHALL drive req_ready=rsp_ready; a simultaneous response handshake and request accept SHALL load the new request that same edge (REQ-016..018 apply) with no IDLE bubble.
REQ-032 Without SHIFT_SEQ_PIPE_EN, DONE SHALL always pass through IDLE, giving at least one idle cycle between responses.

Structure
REQ-033 A shared package shift_pkg SHALL hold the op encodings (OP_SLL, OP_SRL, OP_SRA), the FSM state enum and the default STEP.
REQ-034 A combinational sub-module shift_step SHALL perform one k-bit shift (op, value, k, sign) and be instanced once.

Verification
REQ-035 Directed test: SLL, a=0x00000001, b=31, STEP=4 -> rsp_result=0x80000000, rsp_valid in cycle t+9.
REQ-036 Directed test: SRA, a=0x80000000, b=4 -> 0xF8000000 in cycle t+2; SRL with the same inputs -> 0x08000000.
REQ-037 Directed test: SLL, a=0x12345678, b=0x20 (cnt=0) -> 0x12345678 in cycle t+1; op 4'b0000 -> 0 in cycle t+1.
REQ-038 Directed test: rsp_ready held low for 5 cycles in DONE -> rsp_valid and rsp_result stable and req_ready=0; rsp_ready=1 -> back to IDLE.
REQ-039 Directed test: flush (and separately rst_n=0) in the 3rd SHIFT cycle of b=31 -> IDLE next, no rsp_valid, next request correct.
REQ-040 Directed test (SHIFT_SEQ_PIPE_EN only): back-to-back requests with rsp_ready=1 -> new request accepted on the response edge; both results correct.
